// File: rtl/lab1_imul_prod_accum.sv
// Product accumulator placed downstream of the integer multiplier: sums every
// p_group_len accepted products into one output message. Optional macro
// LAB1_IMUL_PROD_ACCUM_SAT_EN selects unsigned-saturating accumulation.
module lab1_imul_prod_accum #(
    parameter int p_nbits     = 32,
    parameter int p_group_len = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [p_nbits-1:0] istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [p_nbits-1:0] ostream_msg
);

    localparam int CW = $clog2(p_group_len) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(p_group_len - 1);

    typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [p_nbits-1:0] sum_q, sum_d, add_res;
    logic               in_xfer, out_xfer;

    // Handshake outputs are masked while reset is held so nothing transfers.
    assign istream_rdy = (state_q == ACC)  && !reset;
    assign ostream_val = (state_q == DONE) && !reset;
    assign ostream_msg = sum_q;
    assign in_xfer     = istream_val && istream_rdy;
    assign out_xfer    = ostream_val && ostream_rdy;

`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
    logic [p_nbits:0] add_wide;
    assign add_wide = {1'b0, sum_q} + {1'b0, istream_msg};
    // Clamp on carry-out; once at max, further adds keep carrying or add zero.
    assign add_res  = add_wide[p_nbits] ? '1 : add_wide[p_nbits-1:0];
`else
    assign add_res  = sum_q + istream_msg;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        case (state_q)
            ACC: begin
                if (in_xfer) begin
                    sum_d = add_res;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_xfer) begin
                    state_d = ACC;
                    sum_d   = '0;
                end
            end
            default: begin
                state_d = ACC;
                cnt_d   = '0;
                sum_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACC;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_lab1_imul_prod_accum.sv
// Directed bench for lab1_imul_prod_accum: group sums checked via a scoreboard
// queue, handshake timing checked inline; a second instance covers group length 1.
module tb_lab1_imul_prod_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        istream_val = 1'b0, ostream_rdy = 1'b1;
    logic        istream_rdy, ostream_val;
    logic [31:0] istream_msg = '0, ostream_msg;

    logic        val1 = 1'b0, ordy1 = 1'b1;
    logic        rdy1, oval1;
    logic [31:0] msg1 = '0, omsg1;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb[$];
    logic [31:0] m_acc = '0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    lab1_imul_prod_accum #(.p_nbits(32), .p_group_len(4)) dut (
        .clk(clk), .reset(reset),
        .istream_val(istream_val), .istream_rdy(istream_rdy), .istream_msg(istream_msg),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .ostream_msg(ostream_msg)
    );

    lab1_imul_prod_accum #(.p_nbits(32), .p_group_len(1)) dut1 (
        .clk(clk), .reset(reset),
        .istream_val(val1), .istream_rdy(rdy1), .istream_msg(msg1),
        .ostream_val(oval1), .ostream_rdy(ordy1), .ostream_msg(omsg1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        w = {1'b0, a} + {1'b0, b};
`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
        return w[32] ? 32'hFFFF_FFFF : w[31:0];
`else
        return w[31:0];
`endif
    endfunction

    // Drives one product and returns #1 after the edge that accepted it;
    // istream_val is left high so consecutive calls stream back-to-back.
    task automatic send(input logic [31:0] m);
        int  n = 0;
        bit  ok = 1'b0;
        istream_val = 1'b1;
        istream_msg = m;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (istream_rdy) ok = 1'b1;
            n++;
        end
        if (!ok) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        if (ok) begin
            m_acc = model_add(m_acc, m);
            m_cnt++;
            if (m_cnt == 4) begin
                sb.push_back(m_acc);
                m_acc = '0;
                m_cnt = 0;
            end
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected sum.
    always @(negedge clk) begin
        if (!reset && ostream_val && ostream_rdy) begin
            if (sb.size() == 0) chk("unexpected_output", ostream_msg, 32'hDEAD_BEEF);
            else chk("group_sum", ostream_msg, sb.pop_front());
        end
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_istream_rdy", 32'(istream_rdy), 32'd0);
        chk("rst_ostream_val", 32'(ostream_val), 32'd0);
        chk("rst_ostream_msg", ostream_msg, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_istream_rdy", 32'(istream_rdy), 32'd1);

        // Group of 1,2,3,4: output valid the cycle after the 4th transfer.
        @(posedge clk); #1;
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        @(negedge clk);
        chk("lat_ostream_val", 32'(ostream_val), 32'd1);
        chk("lat_istream_rdy", 32'(istream_rdy), 32'd0);
        chk("lat_ostream_msg", ostream_msg, 32'h0000_000A);
        @(posedge clk); #1;
        istream_val = 1'b0;

        // Stalled output: result held, extra input ignored, then accepted.
        ostream_rdy = 1'b0;
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        istream_msg = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ostream_val", 32'(ostream_val), 32'd1);
            chk("stall_ostream_msg", ostream_msg, 32'h0000_000A);
            chk("stall_istream_rdy", 32'(istream_rdy), 32'd0);
            @(posedge clk); #1;
        end
        ostream_rdy = 1'b1;
        send(32'h55); send(32'd1); send(32'd1); send(32'd1);
        istream_val = 1'b0;

        // Overflow: wraps to 0, or saturates when the macro is defined.
        send(32'hFFFF_FFFF); send(32'd1); send(32'd0); send(32'd0);
        istream_val = 1'b0;

        // Reset mid-group discards the partial sum of 5 and 6.
        send(32'd5); send(32'd6);
        istream_val = 1'b0;
        reset = 1'b1;
        m_acc = '0;
        m_cnt = 0;
        #2;
        chk("midrst_istream_rdy", 32'(istream_rdy), 32'd0);
        chk("midrst_ostream_msg", ostream_msg, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(32'd7); send(32'd7); send(32'd7); send(32'd7);
        istream_val = 1'b0;

        // Back-to-back groups with istream_val held high throughout.
        send(32'd1); send(32'd1); send(32'd1); send(32'd1);
        send(32'd2); send(32'd2); send(32'd2); send(32'd2);
        istream_val = 1'b0;

        // Group length 1: each product goes straight to the output.
        val1 = 1'b1; msg1 = 32'h10;
        @(negedge clk);
        chk("g1_rdy_first", 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        msg1 = 32'h20;
        @(negedge clk);
        chk("g1_oval_first", 32'(oval1), 32'd1);
        chk("g1_omsg_first", omsg1, 32'h10);
        chk("g1_rdy_done", 32'(rdy1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("g1_rdy_second", 32'(rdy1), 32'd1);
        chk("g1_oval_cleared", 32'(oval1), 32'd0);
        @(posedge clk); #1;
        val1 = 1'b0;
        @(negedge clk);
        chk("g1_oval_second", 32'(oval1), 32'd1);
        chk("g1_omsg_second", omsg1, 32'h20);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
